// File: rtl/sap_ctrl_seq.sv
// rtl/sap_ctrl_seq.sv - SAP-1 control sequencer: T-state ring, control word decode, run/pause/halt.
// Control word bit order {Cp, Ep, ~Lm, ~CE, ~LI, ~EI, ~La, Ea, Su, Eu, ~Lb, ~Lo}.
module sap_ctrl_seq #(
  parameter bit FAST_NOP = 1'b0,
  parameter int ICNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic [3:0]        opcode,
  output logic [11:0]       con,
  output logic [5:0]        tstate,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [ICNT_W-1:0] instr_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [11:0] CW_IDLE   = 12'h3E3;
  localparam logic [11:0] CW_EP_LM  = 12'h5E3;
  localparam logic [11:0] CW_CP     = 12'hBE3;
  localparam logic [11:0] CW_CE_LI  = 12'h263;
  localparam logic [11:0] CW_EI_LM  = 12'h1A3;
  localparam logic [11:0] CW_CE_LA  = 12'h2C3;
  localparam logic [11:0] CW_CE_LB  = 12'h2E1;
  localparam logic [11:0] CW_EU_LA  = 12'h3C7;
  localparam logic [11:0] CW_SU_LA  = 12'h3CF;
  localparam logic [11:0] CW_EA_LO  = 12'h3F2;

  logic [1:0]        state, state_nxt;
  logic [5:0]        tring, tring_nxt;
  logic              ill_nxt;
  logic [ICNT_W-1:0] cnt_nxt;
  logic              op_known;
  logic              last_t;
  logic              hlt_now;

  always_comb begin
    op_known = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_OUT) || (opcode == OP_HLT);
    hlt_now  = tring[3] && (opcode == OP_HLT);
    // T6 always ends an instruction; FAST_NOP trims trailing idle T-states.
    last_t   = tring[5];
    if (FAST_NOP) begin
      if (tring[4] && (opcode == OP_LDA))
        last_t = 1'b1;
      if (tring[3] && ((opcode == OP_OUT) || !op_known))
        last_t = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    tring_nxt = tring;
    ill_nxt   = illegal;
    cnt_nxt   = instr_count;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          tring_nxt = T1;
        end
      end
      S_RUN: begin
        if (tring[3] && !op_known)
          ill_nxt = 1'b1;
        if (hlt_now) begin
          state_nxt = S_HALT;
          tring_nxt = 6'b0;
        end else if (last_t) begin
          cnt_nxt = instr_count + ICNT_W'(1);
          if (step_mode) begin
            state_nxt = S_PAUSE;
            tring_nxt = 6'b0;
          end else begin
            tring_nxt = T1;
          end
        end else begin
          tring_nxt = {tring[4:0], 1'b0};
        end
      end
      S_PAUSE: begin
        if (step) begin
          state_nxt = S_RUN;
          tring_nxt = T1;
        end
      end
      default: begin
        state_nxt = S_HALT;
        tring_nxt = 6'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      tring       <= 6'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      tring       <= tring_nxt;
      busy        <= (state_nxt == S_RUN);
      halted      <= (state_nxt == S_HALT);
      illegal     <= ill_nxt;
      instr_count <= cnt_nxt;
    end
  end

  assign tstate = tring;

  always_comb begin
    con = CW_IDLE;
    if (state == S_RUN) begin
      case (tring)
        T1: con = CW_EP_LM;
        T2: con = CW_CP;
        T3: con = CW_CE_LI;
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: con = CW_EI_LM;
            OP_OUT:                 con = CW_EA_LO;
            default:                con = CW_IDLE;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         con = CW_CE_LA;
            OP_ADD, OP_SUB: con = CW_CE_LB;
            default:        con = CW_IDLE;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD:  con = CW_EU_LA;
            OP_SUB:  con = CW_SU_LA;
            default: con = CW_IDLE;
          endcase
        end
        default: con = CW_IDLE;
      endcase
    end
  end

endmodule
